// File: rtl/mem_pkg.sv
// Shared types and constants for the stalling data memory.
package mem_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

  // Feedback mask for the Galois LFSR x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Wide enough for 15 base cycles plus 3 random extra cycles.
  typedef logic [4:0] lat_t;

  // Stall length of a request: base latency for its kind plus an optional random extra.
  function automatic lat_t calc_lat(input logic        is_write,
                                    input int unsigned rd_lat,
                                    input int unsigned wr_lat,
                                    input bit          rnd,
                                    input logic [1:0]  extra);
    lat_t base;
    base = is_write ? lat_t'(wr_lat) : lat_t'(rd_lat);
    return base + (rnd ? lat_t'(extra) : lat_t'(0));
  endfunction

endpackage

// File: rtl/stall_data_mem_lfsr16.sv
// Free-running 16-bit Galois LFSR that supplies the pseudo-random extra stall.
module lfsr16
  import mem_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clock,
  input  logic        Resetn,
  output logic [15:0] q
);

  // Shift right every cycle and fold the taps back in when a one drops out.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) q <= SEED;
    else         q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  end

endmodule

// File: rtl/stall_data_mem.sv
// Single-port data RAM that stalls the processor via Waitreq for a configurable
// read/write latency, optionally lengthened by a pseudo-random 0..3 cycles.
module stall_data_mem
  import mem_pkg::*;
#(
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 12,
  parameter int          READ_LAT   = 2,
  parameter int          WRITE_LAT  = 1,
  parameter int          STALL_MODE = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [15:0]       Addr,
  input  logic [DATA_W-1:0] WrData,
  input  logic              Write,
  input  logic              Read,
  output logic [DATA_W-1:0] RdData,
  output logic              Waitreq,
  output logic [15:0]       StallCount
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] word_addr;
  logic [15:0]       lfsr;
  mem_state_t        state_q, state_d;
  lat_t              cnt_q, cnt_d;
  lat_t              lat;
  logic              req;
  logic              wait_raw;
  logic              complete;
  logic [DATA_W-1:0] rd_data_q;
  logic [15:0]       stall_cnt_q;
  logic              unused_bits;

  assign word_addr   = Addr[ADDR_W-1:0];
  assign req         = Read | Write;
  assign lat         = calc_lat(Write, READ_LAT, WRITE_LAT, STALL_MODE != 0, lfsr[1:0]);
  assign unused_bits = ^{Addr, lfsr[15:2]};

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clock  (Clock),
    .Resetn (Resetn),
    .q      (lfsr)
  );

  // Next-state, stall and completion decode for the IDLE/WAIT handshake.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_raw = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (lat == lat_t'(0)) begin
            complete = 1'b1;
          end else begin
            wait_raw = 1'b1;
            state_d  = WAIT;
            cnt_d    = lat - lat_t'(1);
          end
        end
      end
      WAIT: begin
        if (!req) begin
          // Master withdrew the request: abandon it without committing anything.
          state_d = IDLE;
        end else if (cnt_q != lat_t'(0)) begin
          wait_raw = 1'b1;
          cnt_d    = cnt_q - lat_t'(1);
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is forced low while reset is held, even if a request is pending.
  assign Waitreq = wait_raw & Resetn;

  // FSM state and remaining-stall counter.
  always_ff @(posedge Clock or negedge Resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM write port: a write lands only at its completing edge.
  always_ff @(posedge Clock) begin
    // NOTE: the array has no reset so it maps onto RAM macros; contents are undefined at power-up.
    if (complete && Write && Resetn) mem[word_addr] <= WrData;
  end

  // Registered read data, reloaded on every plain read edge and held otherwise.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)             rd_data_q <= '0;
    else if (Read && !Write) rd_data_q <= mem[word_addr];
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                              stall_cnt_q <= '0;
    else if (Waitreq && stall_cnt_q != '1)    stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign RdData     = rd_data_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_stall_data_mem.sv
// Scoreboard bench for stall_data_mem: five instances with different latency setups.
module tb_stall_data_mem;

  localparam int N = 5;  // 0 default, 1 zero-latency, 2 slow write, 3 random stall, 4 saturation

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd    [N];
  logic        wr    [N];
  logic [15:0] addr  [N];
  logic [15:0] wdata [N];
  logic [15:0] rdata [N];
  logic        wreq  [N];
  logic [15:0] scount[N];

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mem_m [N][256];
  logic [15:0] m_lfsr;
  bit          lat0_wait_seen = 1'b0;

  always #5 clk = ~clk;

  stall_data_mem u_dut0 (
    .Clock(clk), .Resetn(rst_n), .Addr(addr[0]), .WrData(wdata[0]), .Write(wr[0]), .Read(rd[0]),
    .RdData(rdata[0]), .Waitreq(wreq[0]), .StallCount(scount[0]));

  stall_data_mem #(.READ_LAT(0), .WRITE_LAT(0)) u_dut1 (
    .Clock(clk), .Resetn(rst_n), .Addr(addr[1]), .WrData(wdata[1]), .Write(wr[1]), .Read(rd[1]),
    .RdData(rdata[1]), .Waitreq(wreq[1]), .StallCount(scount[1]));

  stall_data_mem #(.READ_LAT(2), .WRITE_LAT(4)) u_dut2 (
    .Clock(clk), .Resetn(rst_n), .Addr(addr[2]), .WrData(wdata[2]), .Write(wr[2]), .Read(rd[2]),
    .RdData(rdata[2]), .Waitreq(wreq[2]), .StallCount(scount[2]));

  stall_data_mem #(.STALL_MODE(1), .LFSR_SEED(16'hACE1)) u_dut3 (
    .Clock(clk), .Resetn(rst_n), .Addr(addr[3]), .WrData(wdata[3]), .Write(wr[3]), .Read(rd[3]),
    .RdData(rdata[3]), .Waitreq(wreq[3]), .StallCount(scount[3]));

  stall_data_mem #(.READ_LAT(15), .WRITE_LAT(1)) u_dut4 (
    .Clock(clk), .Resetn(rst_n), .Addr(addr[4]), .WrData(wdata[4]), .Write(wr[4]), .Read(rd[4]),
    .RdData(rdata[4]), .Waitreq(wreq[4]), .StallCount(scount[4]));

  // Reference Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, stepped every clock.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  always @(negedge clk) begin
    if (rst_n && wreq[1] === 1'b1) lat0_wait_seen = 1'b1;
  end

  task automatic idle(input int d, input int n);
    rd[d] = 1'b0; wr[d] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One transaction, entered and left at posedge+1. exp_st < 0 skips the stall-length comparison.
  task automatic txn(input int d, input logic w, input logic r, input logic [15:0] a,
                     input logic [15:0] wd, input int exp_st, input string tag, output int st);
    bit          done;
    logic [15:0] e;
    wr[d] = w; rd[d] = r; addr[d] = a; wdata[d] = wd;
    if (r && !w) exp_q.push_back(mem_m[d][a[7:0]]);
    st = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (wreq[d] === 1'b1) st++;
      else                  done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout: Waitreq still 1 after %0d cycles", tag, st);
      if (r && !w) void'(exp_q.pop_front());
    end else begin
      if (exp_st >= 0) begin
        checks++;
        if (st !== exp_st) begin
          errors++;
          $display("FAIL %s stalls: got %0d expected %0d", tag, st, exp_st);
        end
      end
      if (w) mem_m[d][a[7:0]] = wd;
      if (r && !w && st > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rdata[d] !== e) begin
          errors++;
          $display("FAIL %s rdata: got %h expected %h", tag, rdata[d], e);
        end
      end
    end
    @(posedge clk); #1;
    if (done && r && !w && st == 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rdata[d] !== e) begin
        errors++;
        $display("FAIL %s rdata: got %h expected %h", tag, rdata[d], e);
      end
    end
  endtask

  task automatic check_count(input int d, input logic [15:0] exp, input string tag);
    checks++;
    if (scount[d] !== exp) begin
      errors++;
      $display("FAIL %s StallCount: got %h expected %h", tag, scount[d], exp);
    end
  endtask

  task automatic test_reset();
    rd[0] = 1'b1; addr[0] = 16'h0010;
    #12;
    checks++;
    if (wreq[0] !== 1'b0) begin
      errors++; $display("FAIL reset_waitreq: got %b expected 0", wreq[0]);
    end
    for (int d = 0; d < N; d++) begin
      checks++;
      if (rdata[d] !== 16'h0000) begin
        errors++; $display("FAIL reset_rdata[%0d]: got %h expected 0000", d, rdata[d]);
      end
      check_count(d, 16'h0000, "reset");
    end
    rd[0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int st;
    txn(0, 1'b1, 1'b0, 16'h0010, 16'h1234, 1, "basic_wr", st);
    check_count(0, 16'd1, "basic_wr");
    txn(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 2, "basic_rd", st);
    check_count(0, 16'd3, "basic_rd");
    // Read and Write together behave as a write.
    txn(0, 1'b1, 1'b1, 16'h0007, 16'hBEEF, 1, "rw_both", st);
    txn(0, 1'b0, 1'b1, 16'h0007, 16'h0000, 2, "rw_readback", st);
    check_count(0, 16'd6, "rw_readback");
    idle(0, 1);
  endtask

  task automatic test_back_to_back();
    int st;
    txn(0, 1'b1, 1'b0, 16'h0020, 16'h00A1, 1, "b2b_wr0", st);
    txn(0, 1'b1, 1'b0, 16'h0021, 16'h00A2, 1, "b2b_wr1", st);
    txn(0, 1'b0, 1'b1, 16'h0020, 16'h0000, 2, "b2b_rd0", st);
    txn(0, 1'b0, 1'b1, 16'h0021, 16'h0000, 2, "b2b_rd1", st);
    txn(0, 1'b1, 1'b0, 16'h0021, 16'h5A5A, 1, "b2b_wr2", st);
    txn(0, 1'b0, 1'b1, 16'h0021, 16'h0000, 2, "b2b_rd2", st);
    check_count(0, 16'd15, "b2b");
    idle(0, 1);
  endtask

  task automatic test_zero_latency();
    int st;
    txn(1, 1'b1, 1'b0, 16'h0005, 16'h0A5A, 0, "lat0_wr", st);
    txn(1, 1'b0, 1'b1, 16'h0005, 16'h0000, 0, "lat0_rd", st);
    txn(1, 1'b1, 1'b0, 16'h0006, 16'hC3C3, 0, "lat0_wr2", st);
    txn(1, 1'b0, 1'b1, 16'h0006, 16'h0000, 0, "lat0_rd2", st);
    txn(1, 1'b0, 1'b1, 16'h0005, 16'h0000, 0, "lat0_rd3", st);
    idle(1, 2);
    checks++;
    if (lat0_wait_seen) begin
      errors++; $display("FAIL lat0_never_wait: got Waitreq=1 expected never");
    end
    check_count(1, 16'd0, "lat0");
  endtask

  task automatic test_abort();
    int st;
    txn(2, 1'b1, 1'b0, 16'h0003, 16'h2222, 4, "abort_pre", st);
    wr[2] = 1'b1; rd[2] = 1'b0; addr[2] = 16'h0003; wdata[2] = 16'h1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (wreq[2] !== 1'b1) begin
        errors++; $display("FAIL abort_stall%0d: got %b expected 1", i, wreq[2]);
      end
    end
    @(posedge clk); #1;
    idle(2, 1);
    txn(2, 1'b0, 1'b1, 16'h0003, 16'h0000, 2, "abort_readback", st);
    idle(2, 1);
  endtask

  task automatic test_random_stall();
    int       st, exp_st;
    bit [3:0] seen;
    logic [15:0] a;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      exp_st = 1 + int'(m_lfsr[1:0]);
      txn(3, 1'b1, 1'b0, 16'(i), 16'($urandom), exp_st, "rnd_wr", st);
    end
    for (int i = 0; i < 100; i++) begin
      idle(3, $urandom_range(0, 1));
      a = 16'($urandom_range(0, 15));
      exp_st = 2 + int'(m_lfsr[1:0]);
      seen[m_lfsr[1:0]] = 1'b1;
      txn(3, 1'b0, 1'b1, a, 16'h0000, exp_st, "rnd_rd", st);
      checks++;
      if (st < 2 || st > 5) begin
        errors++; $display("FAIL rnd_range: got %0d expected 2..5", st);
      end
    end
    idle(3, 1);
    checks++;
    if (seen !== 4'hF) begin
      errors++; $display("FAIL rnd_extras_seen: got %b expected 1111", seen);
    end
  endtask

  task automatic test_reset_mid_wait();
    rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = 16'h0010;
    @(negedge clk);
    checks++;
    if (wreq[0] !== 1'b1) begin
      errors++; $display("FAIL midrst_pre: got %b expected 1", wreq[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wreq[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_waitreq: got %b expected 0", wreq[0]);
    end
    checks++;
    if (rdata[0] !== 16'h0000) begin
      errors++; $display("FAIL midrst_rdata: got %h expected 0000", rdata[0]);
    end
    check_count(0, 16'h0000, "midrst");
    rd[0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    begin
      int st;
      txn(0, 1'b0, 1'b1, 16'h0010, 16'h0000, 2, "midrst_after", st);
    end
    idle(0, 1);
  endtask

  task automatic test_saturation();
    rd[4] = 1'b1; wr[4] = 1'b0; addr[4] = 16'h0000;
    repeat (1600) @(posedge clk);
    #1 check_count(4, 16'd1500, "sat_early");
    repeat (68288) @(posedge clk);
    #1 check_count(4, 16'd65520, "sat_near");
    repeat (1120) @(posedge clk);
    #1 check_count(4, 16'hFFFF, "sat_final");
    rd[4] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < N; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_latency();
    test_abort();
    test_random_stall();
    test_reset_mid_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_data_mem.md
Name: stall_data_mem

Overview:
- Parametrised successor to the fixed single-cycle data memory in the processor testbench.
- Synchronous single-port data RAM that drives DataWaitreq with a configurable read and write latency.
- Optional pseudo-random extra stall exercises the processor's memory-stall path.
- Connects directly to the processor data port: DataAddr, DataOut, WriteData, ReadData, DataIn, DataWaitreq.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 12, number of word-address bits used; depth is 2**ADDR_W.
- READ_LAT, 2, base read stall cycles (0 to 15).
- WRITE_LAT, 1, base write stall cycles (0 to 15).
- STALL_MODE, 0, 0 = fixed latency; 1 = base latency plus 0..3 pseudo-random extra cycles.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  asynchronous active-low reset.
- Addr  in  16  word address; only [ADDR_W-1:0] is used.
- WrData  in  DATA_W  write data.
- Write  in  1  write request.
- Read  in  1  read request.
- RdData  out  DATA_W  registered read data.
- Waitreq  out  1  stall; the master holds Addr, WrData, Read and Write stable while it is 1.
- StallCount  out  16  saturating count of cycles with Waitreq=1.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - state=IDLE, cnt=0, RdData=0, StallCount=0, LFSR=LFSR_SEED.
  - Waitreq is 0 while in reset.
  - RAM contents are not cleared and are undefined at power-up.
- Request arbitration:
  - req = Read | Write.
  - Write has priority; Read and Write together is treated as a write and the read is ignored.
- Latency: L = (Write ? WRITE_LAT : READ_LAT) + (STALL_MODE ? lfsr[1:0] : 0). L is computed in IDLE from the current LFSR value.
- States IDLE and WAIT:
  - IDLE, req=0: Waitreq=0, no action.
  - IDLE, req=1, L=0: Waitreq=0 and the transaction completes this cycle.
  - IDLE, req=1, L>0: Waitreq=1 combinationally; at the edge go to WAIT with cnt=L-1.
  - WAIT, cnt!=0: Waitreq=1; decrement cnt.
  - WAIT, cnt==0: Waitreq=0, the transaction completes, and the next state is IDLE.
  - Total stall cycles per transaction = L exactly.
- Completion:
  - A completing write commits WrData to mem[Addr] at that edge.
  - Back-to-back transactions: a new request in the cycle after completion starts fresh from IDLE. There is no forced idle cycle beyond the FSM.
- Read data:
  - On every edge where Read=1 and Write=0, RdData <= mem[Addr] (old contents, before any write at that edge).
  - With L>=1, RdData is valid in the completion cycle.
  - With L=0, the block behaves as a classic synchronous RAM: data appears the cycle after the request.
  - RdData holds its value otherwise.
- Abort: req dropping to 0 while in WAIT returns to IDLE next edge, commits no write, and leaves RdData as last loaded.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clock regardless of mode; unused when STALL_MODE=0.
- StallCount: increments on each edge where Waitreq=1; saturates at 16'hFFFF and never wraps.
- Resetn asserted mid-WAIT: immediate return to IDLE with no commit and Waitreq=0 while asserted.

Decomposition:
- Package mem_pkg:
  - mem_state_t enum {IDLE, WAIT}.
  - LFSR_TAPS constant 16'hB400.
  - lat_t typedef, logic [4:0].
- Sub-module lfsr16: ports Clock, Resetn, seed parameter, q[15:0].
- RAM array, FSM and counter live in stall_data_mem.

Test Plan:
- Default params, Write addr 0x010 data 0x1234 -> Waitreq=1 for 1 cycle, then 0; StallCount=1. Next, Read 0x010 -> Waitreq=1 for 2 cycles; RdData=0x1234 in the completion cycle; StallCount=3.
- READ_LAT=0, WRITE_LAT=0 -> Waitreq never 1. Write 0x0A5A to addr 5, then Read addr 5 -> RdData=0x0A5A one cycle after the read request.
- Read and Write both 1, addr 7, data 0xBEEF -> treated as a write (1 stall cycle); subsequent read of addr 7 returns 0xBEEF.
- Write addr 3 data 0x1111 with WRITE_LAT=4; drop Write after 2 stall cycles -> FSM returns to IDLE; a subsequent read of addr 3 returns the prior contents, not 0x1111.
- STALL_MODE=1, 100 reads -> each stall count lies in [READ_LAT, READ_LAT+3]; all four extras are observed; the stall sequence matches a reference LFSR model from seed 0xACE1.
- Pulse Resetn low mid-WAIT -> Waitreq=0, RdData=0 and StallCount=0 immediately. Hold Waitreq=1 for 70000 cycles in a separate run -> StallCount=0xFFFF.
